// File: rtl/limb_slave_if.sv
// Register-side request bus between the LIMB slave and the internal register file.
interface limb_slave_if;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdat;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdat;
  logic        reg_ack;

  modport master (output reg_addr, reg_wdat, reg_wr, reg_rd,
                  input  reg_rdat, reg_ack);
  modport slave  (input  reg_addr, reg_wdat, reg_wr, reg_rd,
                  output reg_rdat, reg_ack);
endinterface

// File: rtl/limb_slave.sv
// LIMB EC bus slave: byte-wide EC accesses assembled into 32-bit register
// reads/writes with prefetch, timeout abort and a sticky error flag.
module limb_slave #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               ckin,
  input  logic               nreset,
  inout  wire  [7:0]         limb_d,
  input  logic               limb_cmd,
  input  logic               limb_ncs,
  input  logic               limb_nwe,
  input  logic               limb_nrd,
  output logic               limb_nwait,
  output logic               limb_nreq,
  input  logic               irq,
  limb_slave_if.master       bus,
  output logic               err
);

  localparam int unsigned SYNC_W = 12;
  // {cmd, ncs, nwe, nrd, d} at their inactive levels
  localparam logic [SYNC_W-1:0] SYNC_IDLE = 12'h700;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t            state, state_nxt;
  logic [SYNC_W-1:0] sync1, sync2;
  logic              sw_q, sr_q;
  logic [6:0]        addr;
  logic              rmode;
  logic [1:0]        cnt;
  logic [31:0]       wdat, rdword;
  logic [7:0]        tcnt;
  logic              wr_req, rd_req;

  logic              cmd_s, ncs_s, nwe_s, nrd_s;
  logic [7:0]        d_s;
  logic              sw, sr, wr_ev, rd_fall;
  logic              conflict, cmd_ev, dwr_ev, drd_ev;
  logic              busy, tmo;
  logic              rd_oe;
  logic [7:0]        dout;

  assign {cmd_s, ncs_s, nwe_s, nrd_s, d_s} = sync2;

  assign sw       = ~ncs_s & ~nwe_s;
  assign sr       = ~ncs_s & ~nrd_s;
  assign wr_ev    = sw & ~sw_q;
  assign rd_fall  = ~sr & sr_q;
  assign conflict = wr_ev & sr;
  assign cmd_ev   = wr_ev & ~sr & cmd_s;
  assign dwr_ev   = wr_ev & ~sr & ~cmd_s & ~rmode;
  assign drd_ev   = rd_fall & ~cmd_s & rmode;
  assign busy     = (state != IDLE);
  assign tmo      = (tcnt == 8'(TIMEOUT - 1));

  // Read data path follows the raw pins so the EC sees data within its strobe
  assign rd_oe  = ~limb_ncs & ~limb_nrd;
  assign dout   = limb_cmd ? {busy, err, 4'b0000, cnt} : rdword[{cnt, 3'b000} +: 8];
  assign limb_d = rd_oe ? dout : 8'bzzzz_zzzz;

  assign bus.reg_addr = addr;
  assign bus.reg_wdat = wdat;
  assign bus.reg_wr   = wr_req;
  assign bus.reg_rd   = rd_req;

  always_ff @(posedge ckin) begin
    if (!nreset) begin
      sync1 <= SYNC_IDLE;
      sync2 <= SYNC_IDLE;
    end else begin
      sync1 <= {limb_cmd, limb_ncs, limb_nwe, limb_nrd, limb_d};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge ckin) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // A command always wins and aborts any in-flight register access
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dwr_ev && cnt == 2'd3)      state_nxt = WR;
        else if (drd_ev && cnt == 2'd3) state_nxt = RD;
      end
      WR, RD: begin
        if (bus.reg_ack || tmo) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (cmd_ev) state_nxt = d_s[7] ? RD : IDLE;
  end

  always_ff @(posedge ckin) begin
    if (!nreset) begin
      sw_q       <= 1'b0;
      sr_q       <= 1'b0;
      addr       <= 7'd0;
      rmode      <= 1'b0;
      cnt        <= 2'd0;
      wdat       <= 32'd0;
      rdword     <= 32'd0;
      tcnt       <= 8'd0;
      err        <= 1'b0;
      wr_req     <= 1'b0;
      rd_req     <= 1'b0;
      limb_nwait <= 1'b1;
      limb_nreq  <= 1'b1;
    end else begin
      sw_q       <= sw;
      sr_q       <= sr;
      limb_nreq  <= ~irq;
      limb_nwait <= (state_nxt == IDLE);
      wr_req     <= (state_nxt == WR);
      rd_req     <= (state_nxt == RD);
      tcnt       <= (state_nxt != IDLE && state_nxt == state && !cmd_ev) ? tcnt + 8'd1 : 8'd0;
      if (conflict) err <= 1'b1;
      if (cmd_ev) begin
        addr  <= d_s[6:0];
        rmode <= d_s[7];
        cnt   <= 2'd0;
        err   <= 1'b0;
      end else if (busy) begin
        if (bus.reg_ack) begin
          if (state == WR) begin
            addr <= addr + 7'd1;
            cnt  <= 2'd0;
          end else begin
            rdword <= bus.reg_rdat;
          end
        end else if (tmo) begin
          err <= 1'b1;
          if (state == RD) rdword <= 32'hFFFF_FFFF;
        end
        // Data bytes arriving during an access are lost
        if (dwr_ev || drd_ev) err <= 1'b1;
      end else if (dwr_ev) begin
        wdat[{cnt, 3'b000} +: 8] <= d_s;
        cnt <= cnt + 2'd1;
      end else if (drd_ev) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) addr <= addr + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_limb_slave.sv
// Directed bench for limb_slave: table of EC bus operations plus hand-written
// sequences for timeout, busy drop, strobe conflict and reset during a read.
module tb_limb_slave;

  typedef enum {OP_CW, OP_DW, OP_DR, OP_SR, OP_WADDR, OP_WDAT, OP_RADDR, OP_ADDR} op_e;
  typedef struct {
    op_e         op;
    logic [7:0]  din;
    logic [31:0] exp;
  } vec_t;

  logic        ckin = 1'b0;
  logic        nreset;
  wire  [7:0]  limb_d;
  logic [7:0]  ec_d;
  logic        ec_oe;
  logic        limb_cmd, limb_ncs, limb_nwe, limb_nrd;
  logic        limb_nwait, limb_nreq, irq, err;

  logic        ack_en, man_ack;
  int          wcnt;
  logic [31:0] last_wr_addr, last_wr_dat, last_rd_addr;
  int          n_tests = 0;
  int          n_fail  = 0;
  vec_t        vecs[$];

  limb_slave_if bus();

  assign limb_d = ec_oe ? ec_d : 8'bzzzz_zzzz;

  limb_slave #(.TIMEOUT(255)) dut (
    .ckin       (ckin),
    .nreset     (nreset),
    .limb_d     (limb_d),
    .limb_cmd   (limb_cmd),
    .limb_ncs   (limb_ncs),
    .limb_nwe   (limb_nwe),
    .limb_nrd   (limb_nrd),
    .limb_nwait (limb_nwait),
    .limb_nreq  (limb_nreq),
    .irq        (irq),
    .bus        (bus),
    .err        (err)
  );

  always #5 ckin = ~ckin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register-file model: acks two cycles after a request, or follows man_ack
  always @(posedge ckin) begin
    #1;
    if (!ack_en) begin
      bus.reg_ack = man_ack;
      wcnt = 0;
    end else if (bus.reg_ack) begin
      bus.reg_ack = 1'b0;
      wcnt = 0;
    end else if (bus.reg_wr || bus.reg_rd) begin
      wcnt++;
      if (wcnt >= 2) begin
        bus.reg_ack = 1'b1;
        if (bus.reg_wr) begin
          last_wr_addr = 32'(bus.reg_addr);
          last_wr_dat  = bus.reg_wdat;
        end else begin
          last_rd_addr = 32'(bus.reg_addr);
        end
        check("nwait_low_during_access", 32'(limb_nwait), 32'd0);
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic ec_write(input logic c, input logic [7:0] b);
    @(negedge ckin);
    limb_cmd = c; ec_d = b; ec_oe = 1'b1; limb_ncs = 1'b0; limb_nwe = 1'b0;
    repeat (4) @(negedge ckin);
    limb_ncs = 1'b1; limb_nwe = 1'b1;
    repeat (3) @(negedge ckin);
    ec_oe = 1'b0;
  endtask

  task automatic ec_read(input logic c, output logic [7:0] b);
    @(negedge ckin);
    ec_oe = 1'b0; limb_cmd = c; limb_ncs = 1'b0; limb_nrd = 1'b0;
    repeat (2) @(negedge ckin);
    b = limb_d;
    limb_ncs = 1'b1; limb_nrd = 1'b1;
    repeat (4) @(negedge ckin);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400 && limb_nwait !== 1'b1; k++) @(negedge ckin);
    if (limb_nwait !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: nwait %b expected 1 within 400 cycles", limb_nwait);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         nbusy;
    bit         seen;

    nreset = 1'b0; limb_cmd = 1'b0; limb_ncs = 1'b1; limb_nwe = 1'b1; limb_nrd = 1'b1;
    ec_d = 8'h00; ec_oe = 1'b0; irq = 1'b0; ack_en = 1'b1; man_ack = 1'b0;
    bus.reg_rdat = 32'hCAFE_BABE;
    last_wr_addr = 32'hEEEE_EEEE; last_wr_dat = 32'hEEEE_EEEE; last_rd_addr = 32'hEEEE_EEEE;

    repeat (3) @(negedge ckin);
    check("rst_nwait",  32'(limb_nwait), 32'd1);
    check("rst_nreq",   32'(limb_nreq), 32'd1);
    check("rst_reg_wr", 32'(bus.reg_wr), 32'd0);
    check("rst_reg_rd", 32'(bus.reg_rd), 32'd0);
    check("rst_addr",   32'(bus.reg_addr), 32'd0);
    check("rst_wdat",   bus.reg_wdat, 32'd0);
    check("rst_err",    32'(err), 32'd0);
    nreset = 1'b1;
    repeat (2) @(negedge ckin);

    irq = 1'b1;
    @(negedge ckin);
    check("nreq_irq_high", 32'(limb_nreq), 32'd0);
    irq = 1'b0;
    @(negedge ckin);
    check("nreq_irq_low", 32'(limb_nreq), 32'd1);

    vecs.push_back('{OP_CW,    8'h05, 32'h0});
    vecs.push_back('{OP_DW,    8'h11, 32'h0});
    vecs.push_back('{OP_DW,    8'h22, 32'h0});
    vecs.push_back('{OP_DW,    8'h33, 32'h0});
    vecs.push_back('{OP_DW,    8'h44, 32'h0});
    vecs.push_back('{OP_WADDR, 8'h00, 32'h05});
    vecs.push_back('{OP_WDAT,  8'h00, 32'h4433_2211});
    vecs.push_back('{OP_ADDR,  8'h00, 32'h06});
    vecs.push_back('{OP_SR,    8'h00, 32'h00});
    vecs.push_back('{OP_CW,    8'h85, 32'h0});
    vecs.push_back('{OP_RADDR, 8'h00, 32'h05});
    vecs.push_back('{OP_DR,    8'h00, 32'hBE});
    vecs.push_back('{OP_DR,    8'h00, 32'hBA});
    vecs.push_back('{OP_SR,    8'h00, 32'h02});
    vecs.push_back('{OP_DR,    8'h00, 32'hFE});
    vecs.push_back('{OP_DR,    8'h00, 32'hCA});
    vecs.push_back('{OP_RADDR, 8'h00, 32'h06});
    vecs.push_back('{OP_ADDR,  8'h00, 32'h06});
    vecs.push_back('{OP_DR,    8'h00, 32'hBE});
    vecs.push_back('{OP_CW,    8'h7F, 32'h0});
    vecs.push_back('{OP_DW,    8'hA1, 32'h0});
    vecs.push_back('{OP_DW,    8'hB2, 32'h0});
    vecs.push_back('{OP_DW,    8'hC3, 32'h0});
    vecs.push_back('{OP_DW,    8'hD4, 32'h0});
    vecs.push_back('{OP_WADDR, 8'h00, 32'h7F});
    vecs.push_back('{OP_WDAT,  8'h00, 32'hD4C3_B2A1});
    vecs.push_back('{OP_ADDR,  8'h00, 32'h00});

    for (int i = 0; i < vecs.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d_%s", i, vecs[i].op.name());
      case (vecs[i].op)
        OP_CW:    begin ec_write(1'b1, vecs[i].din); wait_idle(); end
        OP_DW:    begin ec_write(1'b0, vecs[i].din); wait_idle(); end
        OP_DR:    begin ec_read(1'b0, b); check(nm, 32'(b), vecs[i].exp); wait_idle(); end
        OP_SR:    begin ec_read(1'b1, b); check(nm, 32'(b), vecs[i].exp); wait_idle(); end
        OP_WADDR: check(nm, last_wr_addr, vecs[i].exp);
        OP_WDAT:  check(nm, last_wr_dat, vecs[i].exp);
        OP_RADDR: check(nm, last_rd_addr, vecs[i].exp);
        OP_ADDR:  check(nm, 32'(bus.reg_addr), vecs[i].exp);
        default:  ;
      endcase
    end

    // Read command with no ack: abort after TIMEOUT cycles
    ack_en = 1'b0;
    @(negedge ckin);
    limb_cmd = 1'b1; ec_d = 8'h80; ec_oe = 1'b1; limb_ncs = 1'b0; limb_nwe = 1'b0;
    nbusy = 0; seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge ckin);
      if (i == 4) begin limb_ncs = 1'b1; limb_nwe = 1'b1; end
      if (i == 7) ec_oe = 1'b0;
      if (!limb_nwait) begin nbusy++; seen = 1'b1; end
      else if (seen) break;
    end
    check("timeout_busy_cycles", 32'(nbusy), 32'd255);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_rd_dropped", 32'(bus.reg_rd), 32'd0);
    ec_read(1'b1, b);
    check("timeout_status", 32'(b), 32'h40);
    ec_read(1'b0, b);
    check("timeout_data_ff", 32'(b), 32'hFF);
    wait_idle();

    // Data byte while a write is pending is dropped
    ec_write(1'b1, 8'h10);
    ec_write(1'b0, 8'h01);
    ec_write(1'b0, 8'h02);
    ec_write(1'b0, 8'h03);
    ec_write(1'b0, 8'h04);
    check("pend_reg_wr", 32'(bus.reg_wr), 32'd1);
    check("pend_nwait", 32'(limb_nwait), 32'd0);
    check("pend_addr", 32'(bus.reg_addr), 32'h10);
    ec_write(1'b0, 8'h99);
    check("drop_err", 32'(err), 32'd1);
    check("drop_wdat", bus.reg_wdat, 32'h0403_0201);
    check("drop_still_wr", 32'(bus.reg_wr), 32'd1);
    @(negedge ckin);
    man_ack = 1'b1;
    repeat (2) @(negedge ckin);
    man_ack = 1'b0;
    check("ack_drops_wr", 32'(bus.reg_wr), 32'd0);
    check("ack_addr_inc", 32'(bus.reg_addr), 32'h11);
    repeat (2) @(negedge ckin);
    ec_write(1'b1, 8'h00);
    wait_idle();
    check("cmd_clears_err", 32'(err), 32'd0);

    // Simultaneous write and read strobes
    @(negedge ckin);
    limb_cmd = 1'b0; ec_d = 8'h55; ec_oe = 1'b1; limb_ncs = 1'b0; limb_nwe = 1'b0; limb_nrd = 1'b0;
    repeat (4) @(negedge ckin);
    limb_ncs = 1'b1; limb_nwe = 1'b1; limb_nrd = 1'b1;
    repeat (4) @(negedge ckin);
    ec_oe = 1'b0;
    check("conflict_err", 32'(err), 32'd1);
    check("conflict_wdat", bus.reg_wdat, 32'h0403_0201);
    check("conflict_idle", 32'(limb_nwait), 32'd1);

    // Reset in the middle of a prefetch; late ack must be ignored
    ec_write(1'b1, 8'h90);
    check("rst_mid_rd_active", 32'(bus.reg_rd), 32'd1);
    @(negedge ckin);
    nreset = 1'b0;
    @(negedge ckin);
    check("rst_mid_rd_drop", 32'(bus.reg_rd), 32'd0);
    check("rst_mid_nwait", 32'(limb_nwait), 32'd1);
    nreset = 1'b1;
    bus.reg_rdat = 32'h1234_5678;
    man_ack = 1'b1;
    repeat (3) @(negedge ckin);
    man_ack = 1'b0;
    repeat (2) @(negedge ckin);
    ec_read(1'b0, b);
    check("late_ack_rdword", 32'(b), 32'h00);
    check("late_ack_addr", 32'(bus.reg_addr), 32'h00);
    check("late_ack_idle", 32'(limb_nwait), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
